// File: rtl/flex_sr_pkg.sv
// Shared types and helpers for the flexible serial-to-parallel deserializer.
// Imported by the beat counter and the deserializer top.
package flex_sr_pkg;

  typedef enum logic {
    DIR_LSB_FIRST = 1'b0,
    DIR_MSB_FIRST = 1'b1
  } dir_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } deser_state_t;

  function automatic int beats(input int num_bits, input int lanes);
    return num_bits / lanes;
  endfunction

endpackage

// File: rtl/flex_beat_counter.sv
// Modulo beat counter with enable and synchronous clear.
// rollover_flag marks the enabled beat that wraps the count to zero.
module flex_beat_counter #(
  parameter int MAX = 8,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic         rollover_flag
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         last;

  assign last          = (cnt_q == W'(MAX - 1));
  assign rollover_flag = en_i && last;
  assign count_o       = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/flex_stp_deser.sv
// Serial-to-parallel deserializer: LANES bits per beat into a NUM_BITS word,
// held under valid/ready with sticky overrun and synchronous abort.
module flex_stp_deser
  import flex_sr_pkg::*;
#(
  parameter int NUM_BITS   = 8,
  parameter int LANES      = 1,
  parameter int RESET_ONES = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clear,
  input  logic                               shift_enable,
  input  logic                               msb_first,
  input  logic [LANES-1:0]                   serial_in,
  output logic [NUM_BITS-1:0]                word_data,
  output logic                               word_valid,
  input  logic                               word_ready,
  output logic                               busy,
  output logic                               overrun,
  output logic [$clog2(NUM_BITS/LANES)-1:0]  beat_count
);

  localparam int BEATS = beats(NUM_BITS, LANES);
  localparam int CW    = $clog2(NUM_BITS / LANES);
  localparam logic [NUM_BITS-1:0] SR_RST =
    (RESET_ONES != 0) ? '1 : '0;

  if (NUM_BITS % LANES != 0) begin : g_bad_width
    $error("NUM_BITS must be a multiple of LANES");
  end
  if (NUM_BITS < 2 * LANES) begin : g_bad_beats
    $error("NUM_BITS must be at least 2*LANES");
  end

  deser_state_t          state_q, state_d;
  dir_t                  dir_q, dir_d, dir_eff;
  logic [NUM_BITS-1:0]   sr_q, sr_d, shifted;
  logic [NUM_BITS-1:0]   wd_q, wd_d;
  logic                  wv_q, wv_d;
  logic                  ovr_q, ovr_d;
  logic                  advance;
  logic                  done;

  assign advance = shift_enable && !clear;

  flex_beat_counter #(
    .MAX (BEATS),
    .W   (CW)
  ) u_cnt (
    .clk           (clk),
    .rst           (rst),
    .clear_i       (clear),
    .en_i          (advance),
    .count_o       (beat_count),
    .rollover_flag (done)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (advance && !done) state_d = SHIFT;
      end
      SHIFT: begin
        if (clear || done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == SHIFT);
  end

  // The first beat of a word uses the live pin; later beats the latch.
  always_comb begin
    dir_eff = (state_q == IDLE) ? dir_t'(msb_first) : dir_q;
    if (dir_eff == DIR_MSB_FIRST)
      shifted = {sr_q[NUM_BITS-LANES-1:0], serial_in};
    else
      shifted = {serial_in, sr_q[NUM_BITS-1:LANES]};
  end

  always_comb begin
    sr_d  = sr_q;
    dir_d = dir_q;
    wd_d  = wd_q;
    wv_d  = wv_q;
    ovr_d = ovr_q;
    if (clear) begin
      sr_d  = SR_RST;
      ovr_d = 1'b0;
    end else if (advance) begin
      sr_d = shifted;
      if (state_q == IDLE) dir_d = dir_eff;
    end
    if (done) begin
      if (wv_q && !word_ready) begin
        ovr_d = 1'b1;
      end else begin
        wd_d = shifted;
        wv_d = 1'b1;
      end
    end else if (word_ready) begin
      wv_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= SR_RST;
      dir_q <= DIR_MSB_FIRST;
      wd_q  <= SR_RST;
      wv_q  <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      dir_q <= dir_d;
      wd_q  <= wd_d;
      wv_q  <= wv_d;
      ovr_q <= ovr_d;
    end
  end

  assign word_data  = wd_q;
  assign word_valid = wv_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_flex_stp_deser.sv
// Bench for flex_stp_deser: LANES=1 and LANES=2 instances, each checked
// every cycle against a word-level model, plus directed literal checks.
module tb_flex_stp_deser;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       msb_first;
  logic       word_ready;
  logic [1:0] se;
  logic [1:0] sin [2];
  bit         armed = 1'b0;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_i
    localparam int L  = g + 1;
    localparam int B  = 8 / L;
    localparam int CW = $clog2(B);

    logic [7:0]    wd;
    logic          wv, bsy, ovr;
    logic [CW-1:0] bc;

    flex_stp_deser #(
      .NUM_BITS   (8),
      .LANES      (L),
      .RESET_ONES (1)
    ) dut (
      .clk          (clk),
      .rst          (rst),
      .clear        (clear),
      .shift_enable (se[g]),
      .msb_first    (msb_first),
      .serial_in    (sin[g][L-1:0]),
      .word_data    (wd),
      .word_valid   (wv),
      .word_ready   (word_ready),
      .busy         (bsy),
      .overrun      (ovr),
      .beat_count   (bc)
    );

    // Word-level model: beat k lands at a lane-aligned slot.
    int         cnt;
    bit         dir;
    logic [7:0] acc, mdata, word, beat;
    bit         mvalid, movr, done;

    always @(posedge clk) begin
      if (rst) begin
        cnt = 0; dir = 1'b1; acc = '0;
        mdata = 8'hFF; mvalid = 1'b0; movr = 1'b0;
      end else begin
        done = 1'b0;
        word = '0;
        if (clear) begin
          cnt = 0; acc = '0; movr = 1'b0;
        end else if (se[g]) begin
          if (cnt == 0) dir = msb_first;
          beat = 8'(sin[g][L-1:0]);
          if (dir) acc = acc | (beat << ((B - 1 - cnt) * L));
          else     acc = acc | (beat << (cnt * L));
          cnt++;
          if (cnt == B) begin
            done = 1'b1; word = acc; cnt = 0; acc = '0;
          end
        end
        if (done) begin
          if (mvalid && !word_ready) movr = 1'b1;
          else begin mdata = word; mvalid = 1'b1; end
        end else if (word_ready) begin
          mvalid = 1'b0;
        end
      end
    end

    always @(negedge clk) begin
      if (armed) begin
        chk($sformatf("i%0d word_data", g), 32'(wd), 32'(mdata));
        chk($sformatf("i%0d word_valid", g), 32'(wv), 32'(mvalid));
        chk($sformatf("i%0d overrun", g), 32'(ovr), 32'(movr));
        chk($sformatf("i%0d busy", g), 32'(bsy), 32'(cnt != 0));
        chk($sformatf("i%0d beat_count", g), 32'(bc), 32'(cnt));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Send byte v on lane-1 instance, first beat = v[7]; tog flips
  // msb_first after beat 1; rdy_last raises word_ready on the last beat.
  task automatic send1(input logic [7:0] v, input bit msb,
                       input bit tog, input bit rdy_last);
    for (int i = 0; i < 8; i++) begin
      se[0] = 1'b1;
      sin[0] = {1'b0, v[7-i]};
      msb_first = (tog && i >= 1) ? !msb : msb;
      if (rdy_last && i == 7) word_ready = 1'b1;
      step();
    end
    se[0] = 1'b0;
  endtask

  task automatic send3_bits();
    for (int i = 0; i < 3; i++) begin
      se[0] = 1'b1;
      sin[0] = {1'b0, i[0] ? 1'b0 : 1'b1};
      step();
    end
    se[0] = 1'b0;
  endtask

  initial begin
    logic [1:0] pairs [4];
    rst = 1'b1; clear = 1'b0; se = '0;
    sin[0] = '0; sin[1] = '0;
    msb_first = 1'b1; word_ready = 1'b1;
    step();
    armed = 1'b1;
    chk("reset word_data", 32'(g_i[0].wd), 32'hFF);
    chk("reset word_valid", 32'(g_i[0].wv), 32'h0);
    chk("reset busy", 32'(g_i[0].bsy), 32'h0);
    step();
    rst = 1'b0;
    step();

    // 1: MSB-first 0xCA, valid for exactly one cycle
    send1(8'hCA, 1'b1, 1'b0, 1'b0);
    chk("t1 data", 32'(g_i[0].wd), 32'hCA);
    chk("t1 valid", 32'(g_i[0].wv), 32'h1);
    step();
    chk("t1 valid drop", 32'(g_i[0].wv), 32'h0);

    // 2: LSB-first with mid-word direction toggle
    send1(8'hCA, 1'b0, 1'b1, 1'b0);
    chk("t2 data", 32'(g_i[0].wd), 32'h53);
    step();

    // 3: two lanes, MSB-first
    pairs[0] = 2'b11; pairs[1] = 2'b00;
    pairs[2] = 2'b10; pairs[3] = 2'b10;
    msb_first = 1'b1;
    for (int i = 0; i < 4; i++) begin
      se[1] = 1'b1;
      sin[1] = pairs[i];
      step();
      chk($sformatf("t3 beat_count %0d", i), 32'(g_i[1].bc),
          32'((i + 1) % 4));
    end
    se[1] = 1'b0;
    chk("t3 data", 32'(g_i[1].wd), 32'hCA);
    step();

    // 4: overrun while word held
    word_ready = 1'b0;
    send1(8'hCA, 1'b1, 1'b0, 1'b0);
    send1(8'hCA, 1'b0, 1'b0, 1'b0);
    chk("t4 data held", 32'(g_i[0].wd), 32'hCA);
    chk("t4 overrun", 32'(g_i[0].ovr), 32'h1);
    word_ready = 1'b1;
    step();
    chk("t4 valid drop", 32'(g_i[0].wv), 32'h0);
    chk("t4 overrun sticky", 32'(g_i[0].ovr), 32'h1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("t4 overrun clr", 32'(g_i[0].ovr), 32'h0);

    // 5: accept and completion on the same edge
    word_ready = 1'b0;
    send1(8'hCA, 1'b1, 1'b0, 1'b0);
    send1(8'hCA, 1'b0, 1'b0, 1'b1);
    chk("t5 data", 32'(g_i[0].wd), 32'h53);
    chk("t5 valid", 32'(g_i[0].wv), 32'h1);
    chk("t5 overrun", 32'(g_i[0].ovr), 32'h0);
    step();

    // 6: abort mid-word via clear, then via rst
    msb_first = 1'b1;
    send3_bits();
    chk("t6 busy", 32'(g_i[0].bsy), 32'h1);
    clear = 1'b1;
    se[0] = 1'b1;
    step();
    se[0] = 1'b0;
    clear = 1'b0;
    chk("t6 clr count", 32'(g_i[0].bc), 32'h0);
    send1(8'hCA, 1'b1, 1'b0, 1'b0);
    chk("t6 data", 32'(g_i[0].wd), 32'hCA);
    send3_bits();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6 rst data", 32'(g_i[0].wd), 32'hFF);
    chk("t6 rst valid", 32'(g_i[0].wv), 32'h0);
    chk("t6 rst busy", 32'(g_i[0].bsy), 32'h0);
    step();
    step();

    armed = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
